seg_scan_display: RTL and testbench

//  N-digit multiplexed hex 7-segment driver with frame-synchronous input capture, PWM brightness,

---
 rtl/seg_scan_display_if.sv | 27 ++
 rtl/seg_scan_display.sv | 136 +++++++++++++
 tb/tb_seg_scan_display.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seg_scan_display_if.sv
// Display-side bundle for seg_scan_display: hex/dot/blank/blink/LZ/brightness in, pins out.
// No latency of its own; master drives the i_* fields, slave drives the o_* fields.
// No backpressure: inputs are free-running levels, sampled by the scanner once per frame.
interface seg_scan_display_if #(
    parameter int N_DIGITS = 4,
    parameter int BRIGHT_W = 4
);
    logic [4*N_DIGITS-1:0] i_data;
    logic [N_DIGITS-1:0]   i_dots;
    logic [N_DIGITS-1:0]   i_blank;
    logic [N_DIGITS-1:0]   i_blink;
    logic                  i_lz_en;
    logic [BRIGHT_W-1:0]   i_bright;
    logic [N_DIGITS-1:0]   o_anodes;
    logic [7:0]            o_segments;
    logic                  o_frame;

    modport master (
        output i_data, i_dots, i_blank, i_blink, i_lz_en, i_bright,
        input  o_anodes, o_segments, o_frame
    );

    modport slave (
        input  i_data, i_dots, i_blank, i_blink, i_lz_en, i_bright,
        output o_anodes, o_segments, o_frame
    );
endinterface

// File: rtl/seg_scan_display.sv
// N-digit multiplexed hex 7-segment scanner with per-frame input capture, PWM, LZ blank, blink.
// Latency: anode/segment pins are registered one cycle after the scan state; inputs are seen from the next frame on.
// No backpressure: inputs are sampled only on the last cycle of each frame, never stalled.
module seg_scan_display #(
    parameter int N_DIGITS = 4,
    parameter int DWELL_W  = 14,
    parameter int BRIGHT_W = 4,
    parameter int BLINK_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    seg_scan_display_if.slave bus
);
    localparam int POS_W = $clog2(N_DIGITS);
    localparam logic [POS_W-1:0] LAST_POS = POS_W'(N_DIGITS - 1);

    logic [DWELL_W-1:0]    dw_cnt;
    logic [POS_W-1:0]      pos;
    logic [BLINK_W-1:0]    frame_cnt;

    logic [4*N_DIGITS-1:0] sh_data;
    logic [N_DIGITS-1:0]   sh_dots;
    logic [N_DIGITS-1:0]   sh_blank;
    logic [N_DIGITS-1:0]   sh_blink;
    logic                  sh_lz_en;
    logic [BRIGHT_W-1:0]   sh_bright;

    logic [N_DIGITS-1:0]   anodes_q;
    logic [7:0]            segments_q;
    logic                  frame_q;

    logic                  dwell_end;
    logic                  frame_end;
    logic [N_DIGITS-1:0]   upper_zero;
    logic [3:0]            nibble;
    logic [6:0]            glyph;
    logic                  digit_on;
    logic [N_DIGITS-1:0]   anodes_nxt;
    logic [7:0]            segments_nxt;

    assign dwell_end = &dw_cnt;
    assign frame_end = dwell_end && (pos == LAST_POS);

    // upper_zero[k]: digit k and every digit to its left hold zero
    for (genvar k = 0; k < N_DIGITS; k++) begin : g_lz
        assign upper_zero[k] = ~|sh_data[4*N_DIGITS-1:4*k];
    end

    // Scan counters: dwell counter, digit position, frame counter for blink phase
    always_ff @(posedge clk) begin
        if (rst) begin
            dw_cnt    <= '0;
            pos       <= '0;
            frame_cnt <= '0;
        end else begin
            dw_cnt <= dw_cnt + DWELL_W'(1);
            if (dwell_end) begin
                pos <= (pos == LAST_POS) ? '0 : pos + POS_W'(1);
            end
            if (frame_end) begin
                frame_cnt <= frame_cnt + BLINK_W'(1);
            end
        end
    end

    // Shadow capture once per frame so a frame never mixes old and new inputs
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_data   <= '0;
            sh_dots   <= '0;
            sh_blank  <= '0;
            sh_blink  <= '0;
            sh_lz_en  <= 1'b0;
            sh_bright <= '0;
        end else if (frame_end) begin
            sh_data   <= bus.i_data;
            sh_dots   <= bus.i_dots;
            sh_blank  <= bus.i_blank;
            sh_blink  <= bus.i_blink;
            sh_lz_en  <= bus.i_lz_en;
            sh_bright <= bus.i_bright;
        end
    end

    // Digit-on decision and glyph lookup for the current scan position
    always_comb begin
        nibble = sh_data[{pos, 2'b00} +: 4];
        glyph  = 7'b0000000;
        case (nibble)
            4'h0: glyph = 7'b1111110;
            4'h1: glyph = 7'b0110000;
            4'h2: glyph = 7'b1101101;
            4'h3: glyph = 7'b1111001;
            4'h4: glyph = 7'b0110011;
            4'h5: glyph = 7'b1011011;
            4'h6: glyph = 7'b1011111;
            4'h7: glyph = 7'b1110000;
            4'h8: glyph = 7'b1111111;
            4'h9: glyph = 7'b1111011;
            4'hA: glyph = 7'b1110111;
            4'hB: glyph = 7'b0011111;
            4'hC: glyph = 7'b1001110;
            4'hD: glyph = 7'b0111101;
            4'hE: glyph = 7'b1001111;
            4'hF: glyph = 7'b1000111;
            default: glyph = 7'b0000000;
        endcase
        digit_on = (dw_cnt[DWELL_W-1 -: BRIGHT_W] < sh_bright)
                && !sh_blank[pos]
                && !(sh_blink[pos] && frame_cnt[BLINK_W-1])
                && !(sh_lz_en && (pos != '0) && upper_zero[pos]);
        anodes_nxt   = '1;
        segments_nxt = 8'h00;
        if (digit_on) begin
            anodes_nxt   = ~({{(N_DIGITS-1){1'b0}}, 1'b1} << pos);
            segments_nxt = {glyph, sh_dots[pos]};
        end
    end

    // Registered pins; o_frame lines up with the cycle the scan state is back at digit 0, dwell 0
    always_ff @(posedge clk) begin
        if (rst) begin
            anodes_q   <= '1;
            segments_q <= 8'h00;
            frame_q    <= 1'b0;
        end else begin
            anodes_q   <= anodes_nxt;
            segments_q <= segments_nxt;
            frame_q    <= frame_end;
        end
    end

    assign bus.o_anodes   = anodes_q;
    assign bus.o_segments = segments_q;
    assign bus.o_frame    = frame_q;
endmodule

// File: tb/tb_seg_scan_display.sv
module tb_seg_scan_display;
    logic clk = 1'b0;
    logic rst = 1'b1;

    seg_scan_display_if #(.N_DIGITS(4), .BRIGHT_W(2)) bus ();

    seg_scan_display #(
        .N_DIGITS(4),
        .DWELL_W (4),
        .BRIGHT_W(2),
        .BLINK_W (2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Per-frame observation record filled by capture()
    int          lit_cnt [4];
    logic [15:0] lit_mask[4];
    logic [7:0]  seg_val [4];
    int          seg_var;
    int          multi_low;
    int          out_of_slot;
    int          dark_seg_bad;
    int          frame_pulses;
    bit          frame_last;

    // Observe the 64 cycles following an o_frame pulse (optionally waiting for the pulse first)
    task automatic capture(input bit sync);
        int n;
        logic [3:0] an;
        logic [3:0] onehot;
        for (int d = 0; d < 4; d++) begin
            lit_cnt[d] = 0; lit_mask[d] = '0; seg_val[d] = '0;
        end
        seg_var = 0; multi_low = 0; out_of_slot = 0; dark_seg_bad = 0;
        frame_pulses = 0; frame_last = 1'b0;
        if (sync) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!bus.o_frame && n < 300);
            n_checks++;
            if (bus.o_frame !== 1'b1) begin
                n_fail++;
                $display("FAIL sync_timeout: o_frame=%b after %0d cycles, required 1", bus.o_frame, n);
            end
        end
        for (int j = 0; j < 64; j++) begin
            @(negedge clk);
            an = bus.o_anodes;
            if (bus.o_frame) begin
                frame_pulses++;
                if (j == 63) frame_last = 1'b1;
            end
            if ($countones(~an) > 1) multi_low++;
            if (an == 4'b1111 && bus.o_segments != 8'h00) dark_seg_bad++;
            for (int d = 0; d < 4; d++) begin
                onehot = 4'b0001 << d;
                if (an == ~onehot) begin
                    if (j / 16 != d) out_of_slot++;
                    lit_cnt[d]++;
                    lit_mask[d][j % 16] = 1'b1;
                    if (lit_cnt[d] == 1) seg_val[d] = bus.o_segments;
                    else if (seg_val[d] != bus.o_segments) seg_var++;
                end
            end
        end
    endtask

    task automatic test_reset();
        int dark_bad;
        int early_frame;
        bit last_frame;
        rst = 1'b1;
        bus.i_data = 16'h1234; bus.i_dots = 4'b0001; bus.i_blank = 4'b0000;
        bus.i_blink = 4'b0000; bus.i_lz_en = 1'b0; bus.i_bright = 2'd3;
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus.o_anodes !== 4'b1111) begin n_fail++; $display("FAIL reset_anodes: got %b, required 1111", bus.o_anodes); end
        n_checks++;
        if (bus.o_segments !== 8'h00) begin n_fail++; $display("FAIL reset_segments: got %h, required 00", bus.o_segments); end
        n_checks++;
        if (bus.o_frame !== 1'b0) begin n_fail++; $display("FAIL reset_frame: got %b, required 0", bus.o_frame); end
        rst = 1'b0;
        dark_bad = 0; early_frame = 0; last_frame = 1'b0;
        for (int j = 0; j < 64; j++) begin
            @(negedge clk);
            if (bus.o_anodes !== 4'b1111) dark_bad++;
            if (j < 63 && bus.o_frame) early_frame++;
            if (j == 63) last_frame = bus.o_frame;
        end
        n_checks++;
        if (dark_bad != 0) begin n_fail++; $display("FAIL first_frame_dark: %0d lit cycles, required 0", dark_bad); end
        n_checks++;
        if (early_frame != 0) begin n_fail++; $display("FAIL first_frame_no_pulse: %0d pulses, required 0", early_frame); end
        n_checks++;
        if (last_frame !== 1'b1) begin n_fail++; $display("FAIL first_frame_pulse_at_64: got %b, required 1", last_frame); end
    endtask

    task automatic test_scan();
        logic [7:0] exp_seg[4];
        exp_seg[0] = 8'h67; exp_seg[1] = 8'hF2; exp_seg[2] = 8'hDA; exp_seg[3] = 8'h60;
        capture(1'b1);
        for (int d = 0; d < 4; d++) begin
            n_checks++;
            if (lit_cnt[d] != 12) begin n_fail++; $display("FAIL scan_count d%0d: got %0d, required 12", d, lit_cnt[d]); end
            n_checks++;
            if (lit_mask[d] !== 16'h0FFF) begin n_fail++; $display("FAIL scan_pwm_mask d%0d: got %h, required 0fff", d, lit_mask[d]); end
            n_checks++;
            if (seg_val[d] !== exp_seg[d]) begin n_fail++; $display("FAIL scan_glyph d%0d: got %b, required %b", d, seg_val[d], exp_seg[d]); end
        end
        n_checks++;
        if (multi_low != 0) begin n_fail++; $display("FAIL scan_one_hot: %0d multi-low cycles, required 0", multi_low); end
        n_checks++;
        if (out_of_slot != 0) begin n_fail++; $display("FAIL scan_slot_order: %0d misplaced cycles, required 0", out_of_slot); end
        n_checks++;
        if (dark_seg_bad != 0) begin n_fail++; $display("FAIL scan_dark_segments: %0d cycles, required 0", dark_seg_bad); end
        n_checks++;
        if (frame_pulses != 1 || !frame_last) begin
            n_fail++; $display("FAIL scan_frame_period: pulses=%0d last=%b, required 1 and 1", frame_pulses, frame_last);
        end
    endtask

    task automatic test_brightness();
        int total;
        bus.i_bright = 2'd1;
        capture(1'b1);
        for (int d = 0; d < 4; d++) begin
            n_checks++;
            if (lit_cnt[d] != 4 || lit_mask[d] !== 16'h000F) begin
                n_fail++; $display("FAIL bright1 d%0d: count=%0d mask=%h, required 4 and 000f", d, lit_cnt[d], lit_mask[d]);
            end
        end
        bus.i_bright = 2'd0;
        capture(1'b1);
        total = lit_cnt[0] + lit_cnt[1] + lit_cnt[2] + lit_cnt[3] + multi_low;
        n_checks++;
        if (total != 0) begin n_fail++; $display("FAIL bright0_dark: %0d lit cycles, required 0", total); end
        bus.i_bright = 2'd3;
    endtask

    task automatic test_lz();
        bus.i_dots = 4'b0000; bus.i_lz_en = 1'b1; bus.i_data = 16'h0050;
        capture(1'b1);
        n_checks++;
        if (lit_cnt[3] != 0 || lit_cnt[2] != 0) begin
            n_fail++; $display("FAIL lz_0050_upper: d3=%0d d2=%0d, required 0 0", lit_cnt[3], lit_cnt[2]);
        end
        n_checks++;
        if (lit_cnt[1] != 12 || seg_val[1] !== 8'hB6) begin
            n_fail++; $display("FAIL lz_0050_d1: count=%0d seg=%h, required 12 b6", lit_cnt[1], seg_val[1]);
        end
        n_checks++;
        if (lit_cnt[0] != 12 || seg_val[0] !== 8'hFC) begin
            n_fail++; $display("FAIL lz_0050_d0: count=%0d seg=%h, required 12 fc", lit_cnt[0], seg_val[0]);
        end
        bus.i_data = 16'h0000;
        capture(1'b1);
        n_checks++;
        if (lit_cnt[3] + lit_cnt[2] + lit_cnt[1] != 0) begin
            n_fail++; $display("FAIL lz_zero_upper: %0d lit cycles, required 0", lit_cnt[3] + lit_cnt[2] + lit_cnt[1]);
        end
        n_checks++;
        if (lit_cnt[0] != 12 || seg_val[0] !== 8'hFC) begin
            n_fail++; $display("FAIL lz_zero_d0: count=%0d seg=%h, required 12 fc", lit_cnt[0], seg_val[0]);
        end
        bus.i_data = 16'h0500;
        capture(1'b1);
        n_checks++;
        if (lit_cnt[1] != 12 || seg_val[1] !== 8'hFC) begin
            n_fail++; $display("FAIL lz_inner_zero_d1: count=%0d seg=%h, required 12 fc", lit_cnt[1], seg_val[1]);
        end
        n_checks++;
        if (lit_cnt[2] != 12 || seg_val[2] !== 8'hB6 || lit_cnt[3] != 0) begin
            n_fail++; $display("FAIL lz_0500_upper: d2=%0d seg=%h d3=%0d, required 12 b6 0", lit_cnt[2], seg_val[2], lit_cnt[3]);
        end
        bus.i_lz_en = 1'b0;
    endtask

    task automatic test_no_tearing();
        logic [7:0] exp_new[4];
        exp_new[0] = 8'h8E; exp_new[1] = 8'h9E; exp_new[2] = 8'h7A; exp_new[3] = 8'h9C;
        bus.i_data = 16'h1111;
        capture(1'b1);
        fork
            capture(1'b0);
            begin
                repeat (20) @(negedge clk);
                bus.i_data = 16'hCDEF;
            end
        join
        for (int d = 0; d < 4; d++) begin
            n_checks++;
            if (seg_val[d] !== 8'h60 || lit_cnt[d] != 12) begin
                n_fail++; $display("FAIL tear_old_value d%0d: seg=%h count=%0d, required 60 12", d, seg_val[d], lit_cnt[d]);
            end
        end
        n_checks++;
        if (seg_var != 0) begin n_fail++; $display("FAIL tear_mid_frame: %0d glyph changes, required 0", seg_var); end
        capture(1'b0);
        for (int d = 0; d < 4; d++) begin
            n_checks++;
            if (seg_val[d] !== exp_new[d]) begin
                n_fail++; $display("FAIL tear_new_value d%0d: got %b, required %b", d, seg_val[d], exp_new[d]);
            end
        end
    endtask

    task automatic test_blink_blank();
        int c1[5];
        int c0[5];
        int sum1;
        int sum0;
        int n;
        bus.i_data = 16'h1234; bus.i_blink = 4'b0010;
        capture(1'b1);
        c1[0] = lit_cnt[1]; c0[0] = lit_cnt[0];
        for (int f = 1; f < 5; f++) begin
            capture(1'b0);
            c1[f] = lit_cnt[1]; c0[f] = lit_cnt[0];
        end
        for (int f = 0; f < 5; f++) begin
            n_checks++;
            if (!(c1[f] == 0 || c1[f] == 12) || c0[f] != 12) begin
                n_fail++; $display("FAIL blink_frame%0d: d1=%0d d0=%0d, required d1 in {0,12} d0=12", f, c1[f], c0[f]);
            end
        end
        for (int f = 0; f < 3; f++) begin
            n_checks++;
            if ((c1[f] == 0) == (c1[f+2] == 0)) begin
                n_fail++; $display("FAIL blink_period f%0d: d1=%0d vs f+2 d1=%0d, required opposite", f, c1[f], c1[f+2]);
            end
        end
        bus.i_blank = 4'b0010;
        sum1 = 0; sum0 = 0;
        capture(1'b1);
        sum1 += lit_cnt[1]; sum0 += lit_cnt[0];
        for (int f = 1; f < 4; f++) begin
            capture(1'b0);
            sum1 += lit_cnt[1]; sum0 += lit_cnt[0];
        end
        n_checks++;
        if (sum1 != 0 || sum0 != 48) begin
            n_fail++; $display("FAIL blank_overrides_blink: d1=%0d d0=%0d, required 0 48", sum1, sum0);
        end
        bus.i_blank = 4'b0000; bus.i_blink = 4'b0000;
        capture(1'b1);
        repeat (5) @(negedge clk);
        n_checks++;
        if (bus.o_anodes !== 4'b1110 || bus.o_segments !== 8'h66) begin
            n_fail++; $display("FAIL pre_reset_lit: anodes=%b seg=%h, required 1110 66", bus.o_anodes, bus.o_segments);
        end
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.o_anodes !== 4'b1111 || bus.o_segments !== 8'h00 || bus.o_frame !== 1'b0) begin
            n_fail++; $display("FAIL mid_frame_reset: anodes=%b seg=%h frame=%b, required 1111 00 0",
                               bus.o_anodes, bus.o_segments, bus.o_frame);
        end
        rst = 1'b0;
        n = 0; sum1 = 0;
        do begin
            @(negedge clk);
            n++;
            if (bus.o_anodes !== 4'b1111) sum1++;
        end while (!bus.o_frame && n < 200);
        n_checks++;
        if (n != 64 || sum1 != 0) begin
            n_fail++; $display("FAIL post_reset_frame: first pulse at %0d lit=%0d, required 64 0", n, sum1);
        end
    endtask

    initial begin
        bus.i_data = '0; bus.i_dots = '0; bus.i_blank = '0;
        bus.i_blink = '0; bus.i_lz_en = 1'b0; bus.i_bright = '0;
        test_reset();
        test_scan();
        test_brightness();
        test_lz();
        test_no_tearing();
        test_blink_blank();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end
endmodule
